// File: rtl/c3lib_scan_pkg.sv
// c3lib_scan_pkg: shared mode type and counter width helper for the scan flop bank
package c3lib_scan_pkg;
  typedef enum logic [1:0] {SCAN_HOLD, SCAN_LOAD, SCAN_SHIFT} scan_mode_e;
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/c3lib_scan_shift_cnt.sv
// c3lib_scan_shift_cnt: saturating shift counter that clears on idle, with full flag
module c3lib_scan_shift_cnt
  import c3lib_scan_pkg::*;
#(
  parameter int MAX = 8,
  localparam int CW = cnt_width(MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift,
  output logic [CW-1:0] cnt,
  output logic          full
);
  assign full = cnt == CW'(MAX);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= shift ? (full ? cnt : cnt + 1'b1) : '0;
endmodule

// File: rtl/c3lib_scan_dff_bank.sv
// c3lib_scan_dff_bank: scan-enabled register bank with optional shadow update stage
module c3lib_scan_dff_bank
  import c3lib_scan_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RST_VAL      = '0,
  parameter bit               UPDATE_STAGE = 1'b1,
  localparam int              CW           = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_en,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out,
  input  logic             update_en,
  output logic [WIDTH-1:0] data_out,
  output logic [CW-1:0]    shift_cnt,
  output logic             chain_full
);
  scan_mode_e       mode;
  logic [WIDTH-1:0] cap;
  always_comb mode = scan_en ? SCAN_SHIFT : data_en ? SCAN_LOAD : SCAN_HOLD;
  always_ff @(posedge clk or posedge rst)
    if (rst) cap <= RST_VAL;
    else cap <= mode == SCAN_SHIFT ? {cap[WIDTH-2:0], scan_in} :
                mode == SCAN_LOAD  ? data_in : cap;
  assign scan_out = cap[WIDTH-1];
  generate
    if (UPDATE_STAGE) begin : g_upd
      logic [WIDTH-1:0] upd;
      always_ff @(posedge clk or posedge rst)
        if (rst) upd <= RST_VAL;
        else if (update_en) upd <= cap;
      assign data_out = upd;
    end else begin : g_no_upd
      logic unused_update_en;
      assign unused_update_en = update_en;
      assign data_out = cap;
    end
  endgenerate
  c3lib_scan_shift_cnt #(.MAX(WIDTH)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .shift(scan_en),
    .cnt  (shift_cnt),
    .full (chain_full)
  );
endmodule

// File: tb/tb_c3lib_scan_dff_bank.sv
// tb_c3lib_scan_dff_bank: directed checks of the scan flop bank with and without update stage
module tb_c3lib_scan_dff_bank;
  logic       clk = 1'b0;
  logic       clk_on = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_en = 1'b0;
  logic       scan_en = 1'b0;
  logic       scan_in = 1'b0;
  logic       update_en = 1'b0;
  logic       so1, so0, full1, full0;
  logic [7:0] do1, do0;
  logic [3:0] cnt1, cnt0;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] pat, so_exp, model;
  always #5 if (clk_on) clk = ~clk;
  c3lib_scan_dff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .UPDATE_STAGE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_en(data_en), .scan_en(scan_en),
    .scan_in(scan_in), .scan_out(so1), .update_en(update_en), .data_out(do1),
    .shift_cnt(cnt1), .chain_full(full1)
  );
  c3lib_scan_dff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .UPDATE_STAGE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_en(data_en), .scan_en(scan_en),
    .scan_in(scan_in), .scan_out(so0), .update_en(update_en), .data_out(do0),
    .shift_cnt(cnt0), .chain_full(full0)
  );
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_data_out1", do1, 8'hA5);
    chk("rst_data_out0", do0, 8'hA5);
    chk("rst_scan_out", {7'd0, so1}, 8'h01);
    chk("rst_cnt", {4'd0, cnt1}, 8'h00);
    chk("rst_full", {7'd0, full1}, 8'h00);
    clk_on = 1'b1;
    step();
    rst = 1'b0;
    data_en = 1'b1; data_in = 8'h3C;
    step();
    data_en = 1'b0;
    chk("load_no_upd1", do1, 8'hA5);
    chk("load_cap0", do0, 8'h3C);
    chk("load_scan_out", {7'd0, so1}, 8'h00);
    update_en = 1'b1;
    step();
    update_en = 1'b0;
    chk("update_out1", do1, 8'h3C);
    data_en = 1'b1; data_in = 8'h81;
    step();
    data_en = 1'b0;
    chk("load81_out1", do1, 8'h3C);
    pat = 8'hB2;
    so_exp = 8'h81;
    for (int i = 0; i < 8; i++) begin
      chk("shift_scan_out", {7'd0, so1}, {7'd0, so_exp[7-i]});
      scan_en = 1'b1; scan_in = pat[7-i];
      step();
      chk("shift_out1_stable", do1, 8'h3C);
      chk("shift_cnt", {4'd0, cnt1}, 8'(i + 1));
      chk("shift_full", {7'd0, full1}, {7'd0, i == 7});
    end
    chk("shift_cap", do0, 8'hB2);
    chk("shift_last_so", {7'd0, so1}, 8'h01);
    scan_en = 1'b0;
    step();
    chk("idle_cnt", {4'd0, cnt1}, 8'h00);
    chk("idle_full", {7'd0, full1}, 8'h00);
    chk("idle_hold", do0, 8'hB2);
    data_en = 1'b1; data_in = 8'h01;
    step();
    scan_en = 1'b1; data_en = 1'b1; data_in = 8'hFF; scan_in = 1'b0; update_en = 1'b1;
    step();
    chk("prio_cap", do0, 8'h02);
    chk("upd_pre_shift", do1, 8'h01);
    scan_en = 1'b0; data_en = 1'b1; data_in = 8'h5A; update_en = 1'b1;
    step();
    chk("upd_load_old", do1, 8'h02);
    chk("upd_load_cap", do0, 8'h5A);
    data_en = 1'b0;
    step();
    update_en = 1'b0;
    chk("upd_later", do1, 8'h5A);
    scan_en = 1'b1; scan_in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("mid_cnt", {4'd0, cnt1}, 8'h05);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cap", do0, 8'hA5);
    chk("mid_rst_upd", do1, 8'hA5);
    chk("mid_rst_cnt", {4'd0, cnt1}, 8'h00);
    chk("mid_rst_so", {7'd0, so1}, 8'h01);
    step();
    chk("rst_held_cnt", {4'd0, cnt1}, 8'h00);
    rst = 1'b0; scan_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("resume_cnt", {4'd0, cnt1}, 8'(i + 1));
      chk("resume_full", {7'd0, full1}, {7'd0, i == 7});
    end
    chk("resume_cap", do0, 8'h00);
    scan_en = 1'b0;
    step();
    model = 8'h00;
    scan_en = 1'b1; update_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      scan_in = (i % 3) == 0;
      model = {model[6:0], scan_in};
      step();
      chk("us0_data_out", do0, model);
      chk("us0_cnt", {4'd0, cnt0}, 8'(i < 8 ? i + 1 : 8));
      chk("us0_full", {7'd0, full0}, {7'd0, i >= 7});
    end
    scan_en = 1'b0; update_en = 1'b0;
    step();
    chk("us0_clear", {4'd0, cnt0}, 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/c3lib_scan_dff_bank.md
# c3lib_scan_dff_bank

Parametrised bank of scan-enabled D flip-flops with an integrated scan chain, optional update (shadow) stage and shift-progress counter. It generalises the single-bit scan/reset flop primitive into a WIDTH-bit register. The bank is used wherever a configuration or status word must be both functionally loaded and scan-shifted without disturbing downstream logic during shift. It sits in the c3lib primitives layer and is instantiated by AIB adapter and CSR blocks.

## Interface
Parameters:
- WIDTH, 8, number of flops in the bank and length of the scan chain; must be ≥ 2.
- RST_VAL, '0, WIDTH-bit reset value of the capture register and of the update register.
- UPDATE_STAGE, 1, 1 = shadow update register drives data_out; 0 = capture register drives data_out directly.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data_in  input  WIDTH  functional load data.
- data_en  input  1  functional load enable.
- scan_en  input  1  scan shift enable; takes priority over data_en.
- scan_in  input  1  serial scan input, shifted into bit 0.
- scan_out  output  1  serial scan output, equal to capture bit WIDTH-1.
- update_en  input  1  copies the capture register into the update register (UPDATE_STAGE=1 only).
- data_out  output  WIDTH  parallel output.
- shift_cnt  output  $clog2(WIDTH+1)  number of consecutive shift cycles, saturating at WIDTH.
- chain_full  output  1  high when shift_cnt == WIDTH.

## Operation
- Capture register cap[WIDTH-1:0] has three modes, evaluated per cycle:
  - scan_en=1: shift, cap <= {cap[WIDTH-2:0], scan_in}.
  - scan_en=0, data_en=1: load, cap <= data_in.
  - otherwise: hold.
- scan_out = cap[WIDTH-1]. No combinational path runs from scan_in to scan_out.
- Update register upd, present only when UPDATE_STAGE=1:
  - update_en=1: upd <= cap, using the pre-edge value of cap.
  - otherwise: hold.
  - data_out = upd.
- When UPDATE_STAGE=0, data_out = cap and update_en is ignored.
- shift_cnt:
  - Increments on each cycle with scan_en=1 and saturates at WIDTH.
  - Clears to 0 on any cycle with scan_en=0.
- chain_full = (shift_cnt == WIDTH), derived combinationally from the registered count.
- Reset (rst=1) forces the following immediately, regardless of clk:
  - cap = RST_VAL and upd = RST_VAL.
  - shift_cnt = 0 and chain_full = 0.
  - scan_out = RST_VAL[WIDTH-1] and data_out = RST_VAL.
- Reset mid-shift discards all partially shifted data. Shifting resumes from the reset state on the first edge after rst deasserts.

## Timing
- Load latency: data_in appears on cap one edge after data_en.
  - UPDATE_STAGE=0: it appears on data_out at that same edge.
  - UPDATE_STAGE=1: it appears on data_out only after a later update_en edge.
- Shift latency: a bit driven on scan_in reaches scan_out after exactly WIDTH consecutive shift edges.
- Simultaneous scan_en and data_en: shift wins and data_in is ignored.
- Simultaneous update_en and scan_en: upd captures the pre-shift cap value, and the shift proceeds in the same edge.
- Simultaneous update_en and data_en: upd captures the old cap value; the new data_in reaches upd only on a later update_en.
- During a shift with UPDATE_STAGE=1, data_out is stable and never toggles.
- chain_full rises on the WIDTH-th consecutive shift edge. It stays high while scan_en remains 1 and falls on the first edge with scan_en=0.

## Structure
- Package c3lib_scan_pkg holds:
  - typedef scan_mode_e {SCAN_HOLD, SCAN_LOAD, SCAN_SHIFT} for the decoded mode.
  - A function computing the shift_cnt width, $clog2(WIDTH+1).
- Sub-module c3lib_scan_shift_cnt implements the saturating, clear-on-idle counter and the chain_full compare. It is parametrised by MAX=WIDTH.
- The capture and update registers stay in the top module. A generate branch on UPDATE_STAGE selects whether the update register exists.

## Test plan
Scenarios use WIDTH=8 and RST_VAL=8'hA5 unless stated.
- Reset: assert rst with no clock running -> data_out=8'hA5, scan_out=1, shift_cnt=0 and chain_full=0 immediately.
- Load and update: data_en=1 with data_in=8'h3C for one cycle, then update_en=1 -> data_out stays 8'hA5 after the load edge and becomes 8'h3C after the update edge.
- Full shift: load 8'h81, then shift 8 cycles with scan_in pattern 1,0,1,1,0,0,1,0 ->
  - scan_out emits 1,0,0,0,0,0,0,1.
  - cap ends at 8'hB2.
  - chain_full rises on the 8th edge.
  - data_out stays unchanged throughout.
- Priority: scan_en=1 and data_en=1 with data_in=8'hFF and scan_in=0, starting from cap=8'h01 -> cap=8'h02 and data_in is ignored.
- Reset mid-shift: after 5 shift cycles assert rst, then release it and shift again -> cap returns to 8'hA5, shift_cnt restarts from 0, and chain_full rises only after 8 further shifts.
- UPDATE_STAGE=0 with scan_en held high for 12 cycles -> data_out follows each shift edge, update_en has no effect, and shift_cnt saturates at 8.
